// File: rtl/usb_endp_seq_pkg.sv
// Shared types for the USB endpoint transaction sequencer: response codes,
// token encodings, sequencer states and the default turnaround timeout.
package usb_endp_seq_pkg;

  typedef enum logic [1:0] {
    RESP_ACK   = 2'b00,
    RESP_NAK   = 2'b01,
    RESP_STALL = 2'b10,
    RESP_DATA  = 2'b11
  } resp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_RESPOND,
    ST_WAIT_HS
  } seq_state_e;

  localparam logic [1:0] TOK_OUT   = 2'b01;
  localparam logic [1:0] TOK_IN    = 2'b10;
  localparam logic [1:0] TOK_SETUP = 2'b11;

  localparam int BTO_DEFAULT = 64;

endpackage

// File: rtl/usb_endp_seq_state.sv
// Per-endpoint DATA toggle, stall and armed bits. A CPU config write to the
// same endpoint overrides any sequencer update on the bits it touches.
module usb_endp_seq_state #(
  parameter int NUM_ENDP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          seq_endp,
  input  logic                seq_tgl_we,
  input  logic                seq_tgl_val,
  input  logic                seq_arm_clr,
  input  logic                seq_stall_clr,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_endp,
  input  logic                cfg_stall,
  input  logic                cfg_arm,
  input  logic                cfg_tgl_clr,
  output logic [NUM_ENDP-1:0] tgl_vec,
  output logic [NUM_ENDP-1:0] stall_vec,
  output logic [NUM_ENDP-1:0] armed_vec
);

  // Config write is placed after the sequencer update so it wins per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_vec   <= '0;
      stall_vec <= '0;
      armed_vec <= '0;
    end else begin
      for (int i = 0; i < NUM_ENDP; i++) begin
        if (seq_endp == 4'(i)) begin
          if (seq_tgl_we)    tgl_vec[i]   <= seq_tgl_val;
          if (seq_arm_clr)   armed_vec[i] <= 1'b0;
          if (seq_stall_clr) stall_vec[i] <= 1'b0;
        end
        if (cfg_wr && (cfg_endp == 4'(i))) begin
          stall_vec[i] <= cfg_stall;
          armed_vec[i] <= cfg_arm;
          if (cfg_tgl_clr) tgl_vec[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/usb_endp_seq.sv
// USB endpoint transaction sequencer: chooses ACK/NAK/STALL/DATA responses,
// tracks data toggles and enforces the bus turnaround timeout.
module usb_endp_seq
  import usb_endp_seq_pkg::*;
#(
  parameter int NUM_ENDP   = 4,
  parameter int BTO_CYCLES = BTO_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tok_valid,
  input  logic [1:0]          tok_pid,
  input  logic [3:0]          tok_endp,
  input  logic                dat_pid_valid,
  input  logic                dat_pid,
  input  logic                dat_done,
  input  logic                dat_crc_ok,
  input  logic                dat_overflow,
  input  logic                hs_ack,
  input  logic                tx_done,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_endp,
  input  logic                cfg_stall,
  input  logic                cfg_arm,
  input  logic                cfg_tgl_clr,
  output logic                resp_valid,
  output logic [1:0]          resp_code,
  output logic                resp_tgl,
  output logic [3:0]          endp_sel,
  output logic                dat_discard,
  output logic                token_done,
  output logic                bto,
  output logic [NUM_ENDP-1:0] stall_vec,
  output logic [NUM_ENDP-1:0] armed_vec
);

  localparam int TW = (BTO_CYCLES > 1) ? $clog2(BTO_CYCLES) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(BTO_CYCLES - 1);

  seq_state_e        state_q, state_d;
  resp_code_e        code_q, code_d;
  logic [3:0]        endp_d;
  logic              tgl_d, exp_q, exp_d, setup_q, setup_d, rx_pid_q, rx_pid_d;
  logic              pend_q, pend_d, discard_d, done_d, bto_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NUM_ENDP-1:0] tgl_vec;
  logic              t_stall, t_armed, t_tgl, s_stall, s_armed, tok_in_range, start_tok;
  logic [3:0]        seq_endp;
  logic              seq_tgl_we, seq_tgl_val, seq_arm_clr, seq_stall_clr;

  usb_endp_seq_state #(.NUM_ENDP(NUM_ENDP)) u_state (
    .clk           (clk),
    .rst_n         (rst_n),
    .seq_endp      (seq_endp),
    .seq_tgl_we    (seq_tgl_we),
    .seq_tgl_val   (seq_tgl_val),
    .seq_arm_clr   (seq_arm_clr),
    .seq_stall_clr (seq_stall_clr),
    .cfg_wr        (cfg_wr),
    .cfg_endp      (cfg_endp),
    .cfg_stall     (cfg_stall),
    .cfg_arm       (cfg_arm),
    .cfg_tgl_clr   (cfg_tgl_clr),
    .tgl_vec       (tgl_vec),
    .stall_vec     (stall_vec),
    .armed_vec     (armed_vec)
  );

  // Endpoint state looked up both for the incoming token and the latched endpoint.
  always_comb begin
    t_stall = 1'b0;
    t_armed = 1'b0;
    t_tgl   = 1'b0;
    s_stall = 1'b0;
    s_armed = 1'b0;
    for (int i = 0; i < NUM_ENDP; i++) begin
      if (tok_endp == 4'(i)) begin
        t_stall = stall_vec[i];
        t_armed = armed_vec[i];
        t_tgl   = tgl_vec[i];
      end
      if (endp_sel == 4'(i)) begin
        s_stall = stall_vec[i];
        s_armed = armed_vec[i];
      end
    end
    tok_in_range = (int'(tok_endp) < NUM_ENDP);
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    endp_d        = endp_sel;
    tgl_d         = resp_tgl;
    exp_d         = exp_q;
    setup_d       = setup_q;
    rx_pid_d      = dat_pid_valid ? dat_pid : rx_pid_q;
    timer_d       = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
    pend_d        = pend_q;
    discard_d     = 1'b0;
    done_d        = 1'b0;
    bto_d         = 1'b0;
    start_tok     = 1'b0;
    seq_endp      = endp_sel;
    seq_tgl_we    = 1'b0;
    seq_tgl_val   = 1'b0;
    seq_arm_clr   = 1'b0;
    seq_stall_clr = 1'b0;

    case (state_q)
      ST_IDLE: start_tok = tok_valid;
      ST_WAIT_DATA: begin
        if (tok_valid) begin
          bto_d     = 1'b1;
          start_tok = 1'b1;
          state_d   = ST_IDLE;
        end else if (dat_done) begin
          state_d = ST_RESPOND;
          if (!dat_crc_ok) begin
            discard_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (dat_overflow) begin
            discard_d = 1'b1;
            code_d    = RESP_NAK;
          end else if (!setup_q && s_stall) begin
            discard_d = 1'b1;
            code_d    = RESP_STALL;
          end else if (!setup_q && !s_armed) begin
            discard_d = 1'b1;
            code_d    = RESP_NAK;
          end else if (rx_pid_d != exp_q) begin
            // Duplicate of an already-acknowledged packet: re-ACK, keep toggle.
            discard_d = 1'b1;
            code_d    = RESP_ACK;
          end else begin
            code_d      = RESP_ACK;
            seq_tgl_we  = 1'b1;
            seq_tgl_val = ~exp_q;
            seq_arm_clr = 1'b1;
            pend_d      = 1'b1;
          end
        end else if (timer_q == T_MAX) begin
          bto_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESPOND: begin
        if (tx_done) begin
          state_d = (code_q == RESP_DATA) ? ST_WAIT_HS : ST_IDLE;
          timer_d = '0;
          done_d  = pend_q;
          pend_d  = 1'b0;
        end
      end
      ST_WAIT_HS: begin
        if (tok_valid) begin
          bto_d     = 1'b1;
          start_tok = 1'b1;
          state_d   = ST_IDLE;
        end else if (hs_ack) begin
          seq_tgl_we  = 1'b1;
          seq_tgl_val = ~resp_tgl;
          seq_arm_clr = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else if (timer_q == T_MAX) begin
          bto_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A token aborting a wait state is handled exactly as one arriving in IDLE.
    if (start_tok && tok_in_range) begin
      case (tok_pid)
        TOK_IN: begin
          endp_d  = tok_endp;
          pend_d  = 1'b0;
          state_d = ST_RESPOND;
          tgl_d   = t_tgl;
          if (t_stall)       code_d = RESP_STALL;
          else if (!t_armed) code_d = RESP_NAK;
          else               code_d = RESP_DATA;
        end
        TOK_OUT: begin
          endp_d  = tok_endp;
          pend_d  = 1'b0;
          timer_d = '0;
          state_d = ST_WAIT_DATA;
          exp_d   = t_tgl;
          setup_d = 1'b0;
        end
        TOK_SETUP: begin
          endp_d        = tok_endp;
          pend_d        = 1'b0;
          timer_d       = '0;
          state_d       = ST_WAIT_DATA;
          exp_d         = 1'b0;
          setup_d       = 1'b1;
          seq_endp      = tok_endp;
          seq_stall_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= RESP_ACK;
      endp_sel    <= '0;
      resp_tgl    <= 1'b0;
      exp_q       <= 1'b0;
      setup_q     <= 1'b0;
      rx_pid_q    <= 1'b0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      dat_discard <= 1'b0;
      token_done  <= 1'b0;
      bto         <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      endp_sel    <= endp_d;
      resp_tgl    <= tgl_d;
      exp_q       <= exp_d;
      setup_q     <= setup_d;
      rx_pid_q    <= rx_pid_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      dat_discard <= discard_d;
      token_done  <= done_d;
      bto         <= bto_d;
    end
  end

  assign resp_valid = (state_q == ST_RESPOND);
  assign resp_code  = code_q;

endmodule
